fetch_unit: RTL and testbench

//   RV32I instruction-fetch stage; sits directly upstream of the decoder.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x {pc, insn}, combinational head, flush empties it.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  fifo_entry_t     push_data,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output fifo_entry_t     head,
    output logic [XLEN-1:0] last_pc
);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is reset (it is tiny) so the empty-buffer ir_pc reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head    = mem[rd_ptr];
    assign last_pc = mem[rd_ptr - AW'(1)].pc;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-based issue to a 1-cycle imem, redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = CW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic            inflight_q;
    logic [CW-1:0]   count;
    fifo_entry_t     head;
    logic [XLEN-1:0] last_pc;
    logic [PW-1:0]   pending;
    logic            pop;
    logic            push;
    logic            credit;
    logic            unused_ok;

    assign pop     = ir_valid & ir_ready;
    assign pending = PW'(count) + PW'(inflight_q) - PW'(pop);
    assign credit  = pending < PW'(FIFO_DEPTH);

    // NOTE: rst_n gates the request combinationally so imem_req reads 0 for the whole reset.
    assign imem_req  = rst_n & (redirect_valid | credit);
    assign imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;

    // A response landing in a redirect cycle belongs to the old stream: the flush
    // drops it, so the redirected request's own response is never discarded.
    assign push = inflight_q & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                pc_q   <= imem_addr + XLEN'(4);
                addr_q <= imem_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: addr_q, insn: imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head),
        .last_pc   (last_pc)
    );

    assign ir_valid = (count != '0) & ~redirect_valid;
    assign ir       = (count != '0) ? head.insn : NOP_INSN;
    assign ir_pc    = (count != '0) ? head.pc : last_pc;

    assign unused_ok = &{1'b0, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed literals.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ir;
    logic [31:0] w_ir_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .ir_valid(w_valid), .ir_ready(w_ready), .ir(w_ir), .ir_pc(w_ir_pc)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'hb50633;
        if (a == 32'h4) return 32'h40b60633;
        return {a[15:0], ~a[17:2]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns data exactly one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_f(imem_addr) : $urandom;
        w_rdata    <= w_req ? mem_f(w_addr) : $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PCs buffered (queue), next fetch address, whether a response is due.
    logic [31:0] mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_prev;
    bit          m_inflight;

    always @(negedge clk) begin
        bit          m_valid;
        bit          m_pop;
        bit          m_req;
        logic [31:0] m_addr;
        if (!rst_n) begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_ir_valid", 32'(ir_valid), 32'd0);
            check("rst_ir", ir, NOP);
            mq.delete();
            m_inflight = 1'b0;
            m_fetch    = 32'h0;
        end else begin
            m_valid = (mq.size() != 0) && !redirect_valid;
            m_pop   = m_valid && ir_ready;
            m_req   = redirect_valid || (mq.size() + int'(m_inflight) - int'(m_pop) < DEPTH);
            m_addr  = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_fetch;
            check("ir_valid", 32'(ir_valid), 32'(m_valid));
            check("imem_req", 32'(imem_req), 32'(m_req));
            if (m_req) check("imem_addr", imem_addr, m_addr);
            if (m_valid) begin
                check("ir_pc", ir_pc, mq[0]);
                check("ir", ir, mem_f(mq[0]));
            end
            if (redirect_valid) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_inflight) mq.push_back(m_prev);
            end
            m_inflight = m_req;
            m_prev     = m_addr;
            if (m_req) m_fetch = m_addr + 32'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle redirect, then the first redirected instruction two cycles later.
    task automatic redirect_once(input logic [31:0] target, input logic [31:0] exp_pc, input string tag);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        ir_ready       = 1'b1;
        @(negedge clk);
        check({tag, "_valid_low"}, 32'(ir_valid), 32'd0);
        check({tag, "_addr"}, imem_addr, exp_pc);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check({tag, "_gap"}, 32'(ir_valid), 32'd0);
        @(negedge clk);
        check({tag, "_first_valid"}, 32'(ir_valid), 32'd1);
        check({tag, "_first_pc"}, ir_pc, exp_pc);
        @(negedge clk);
        check({tag, "_second_pc"}, ir_pc, exp_pc + 32'd4);
    endtask

    initial begin
        rst_n = 1'b0;
        ir_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        w_redirect_valid = 1'b0;
        w_redirect_pc = 32'h0;
        w_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ir_pc", ir_pc, 32'h0);

        // Startup latency and first two words.
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_c0_valid", 32'(ir_valid), 32'd0);
        check("t1_c0_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("t1_c1_valid", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check("t1_c2_valid", 32'(ir_valid), 32'd1);
        check("t1_c2_ir", ir, 32'hb50633);
        check("t1_c2_pc", ir_pc, 32'h0);
        check("t5_wrap_pc0", w_ir_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t1_c3_ir", ir, 32'h40b60633);
        check("t1_c3_pc", ir_pc, 32'h4);
        check("t5_wrap_pc1", w_ir_pc, 32'h0);

        // Stall: buffer fills, requests stop, head holds.
        tick();
        ir_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_stall_req", 32'(imem_req), 32'd0);
        check("t2_stall_valid", 32'(ir_valid), 32'd1);
        check("t2_stall_pc", ir_pc, 32'h8);
        tick();
        ir_ready = 1'b1;
        @(negedge clk);
        check("t2_resume_pc0", ir_pc, 32'h8);
        @(negedge clk);
        check("t2_resume_pc1", ir_pc, 32'hC);

        // Redirect with a full buffer, then while streaming.
        tick();
        ir_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_once(32'h100, 32'h100, "t3_full");
        redirect_once(32'h203, 32'h200, "t4_mask");

        // Back-to-back redirects: latest wins.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_b2b_gap", 32'(ir_valid), 32'd0);
        @(negedge clk);
        check("t4_b2b_valid", 32'(ir_valid), 32'd1);
        check("t4_b2b_pc", ir_pc, 32'h80);

        // Reset mid-stream with a request in flight.
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t6_imm_valid", 32'(ir_valid), 32'd0);
        check("t6_imm_req", 32'(imem_req), 32'd0);
        check("t6_imm_ir", ir, NOP);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_restart_pc", ir_pc, 32'h0);
        check("t6_restart_ir", ir, 32'hb50633);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            ir_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                redirect_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rand_rst_valid", 32'(ir_valid), 32'd0);
                check("rand_rst_req", 32'(imem_req), 32'd0);
                repeat (2) tick();
                rst_n = 1'b1;
            end
        end
        tick();
        redirect_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
